ahb_boot_ram: RTL

// - AHB-Lite slave wrapping the on-chip program/data RAM; downstream of spi_loader.
// - Accepts the loader's word writes while the core is held in reset, then serves the core's fetches and loads/stores.
// - Zero-wait OKAY transfers; two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_ram_sdp.sv | 43 ++++
 rtl/ahb_boot_ram.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings used by the boot RAM slave, the SPI loader master
// and the core bus interface. Also holds the error-response state type used by
// AHB-Lite slaves in this codebase.
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Two-cycle ERROR response: ERR1 stalls the bus, ERR2 completes it.
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

endpackage

// File: rtl/ahb_ram_sdp.sv
// ---------------------------------------------------------------------------
// ahb_ram_sdp
// Simple dual-port RAM, 32-bit wide, 2**ADDR_WIDTH words. One synchronous
// write port with per-byte enables, one synchronous read port. No reset so the
// array maps onto block RAM.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write word address
//   wbe    - byte enables, bit i covers wdata[8*i+7:8*i]
//   wdata  - write data
//   re     - read enable; rdata holds when low
//   raddr  - read word address
//   rdata  - registered read data (old contents on same-address write)
// ---------------------------------------------------------------------------
module ahb_ram_sdp #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [3:0]            wbe,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_boot_ram.sv
// ---------------------------------------------------------------------------
// ahb_boot_ram
// AHB-Lite slave in front of the on-chip program/data RAM. The SPI loader
// fills it with word writes while the core is held in reset; afterwards the
// core fetches and loads/stores through it. Legal transfers complete with zero
// wait states; illegal ones (out of range, bad size, misaligned) get the
// two-cycle ERROR response and never touch the RAM.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   hsel, hready    - slave select / bus-level ready (qualify address phase)
//   haddr, hwrite,
//   hsize, htrans   - address-phase controls
//   hwdata          - write data (data phase)
//   hreadyout,hresp - slave ready / response
//   hrdata          - read data (data phase), holds between reads
// ---------------------------------------------------------------------------
module ahb_boot_ram
  import ahb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  // Byte-address bits covered by the RAM; everything above must match BASE_ADDR.
  localparam int BA_W = ADDR_WIDTH + 2;

  err_state_t state;

  logic                  acc_p0, legal_p0, wr_p0, rd_p0, err_p0;
  logic [ADDR_WIDTH-1:0] word_p0;
  logic [3:0]            mask_p0;
  logic                  fwd_hit_p0;

  logic                  wr_vld_p1, rd_vld_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [3:0]            wr_mask_p1;
  logic [3:0]            fwd_mask_p1;
  logic [31:0]           fwd_data_p1;
  logic [31:0]           ram_rdata_p1;
  logic [31:0]           rd_merged_p1;
  logic [31:0]           hrdata_hold;

  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] sz);
    logic in_range;
    logic aligned;
    // BASE_ADDR is aligned to the RAM size, so an upper-bit match is an exact
    // range check with no wrap.
    in_range = (a[31:BA_W] == BASE_ADDR[31:BA_W]);
    case (sz)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = ~a[0];
      HSIZE_WORD: aligned = (a[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
    return in_range & aligned;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    case (sz)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [3:0]  m,
                                              input logic [31:0] fwd,
                                              input logic [31:0] ram);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = m[i] ? fwd[i*8 +: 8] : ram[i*8 +: 8];
    end
    return r;
  endfunction

  // ---- p0: address phase decode ----
  // ERR1 drives hreadyout low, so nothing is sampled there even if the
  // decoder's hready were to disagree.
  assign acc_p0     = hsel & hready & htrans[1] & (state != ST_ERR1);
  assign legal_p0   = is_legal(haddr, hsize);
  assign wr_p0      = acc_p0 & legal_p0 & hwrite;
  assign rd_p0      = acc_p0 & legal_p0 & ~hwrite;
  assign err_p0     = acc_p0 & ~legal_p0;
  assign word_p0    = haddr[BA_W-1:2];
  assign mask_p0    = lane_mask(haddr[1:0], hsize);
  // A read hitting the word whose write data is on the bus right now would
  // otherwise see stale RAM contents.
  assign fwd_hit_p0 = wr_vld_p1 & (wr_addr_p1 == word_p0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_vld_p1   <= 1'b0;
      rd_vld_p1   <= 1'b0;
      hrdata_hold <= 32'h0;
    end else begin
      wr_vld_p1 <= wr_p0;
      rd_vld_p1 <= rd_p0;
      if (rd_vld_p1) hrdata_hold <= rd_merged_p1;
    end
  end

  always_ff @(posedge clk) begin
    wr_addr_p1  <= word_p0;
    wr_mask_p1  <= mask_p0;
    fwd_mask_p1 <= fwd_hit_p0 ? wr_mask_p1 : 4'b0000;
    fwd_data_p1 <= hwdata;
  end

  // Error response FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_OKAY;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          if (err_p0) begin
            state     <= ST_ERR1;
            hreadyout <= 1'b0;
            hresp     <= HRESP_ERROR;
          end else begin
            state     <= ST_OKAY;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  // ---- p1: data phase ----
  // The write commits on the edge ending its data phase; a reset on that edge
  // drops it.
  ahb_ram_sdp #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_vld_p1 & reset),
    .waddr (wr_addr_p1),
    .wbe   (wr_mask_p1),
    .wdata (hwdata),
    .re    (rd_p0),
    .raddr (word_p0),
    .rdata (ram_rdata_p1)
  );

  assign rd_merged_p1 = merge_lanes(fwd_mask_p1, fwd_data_p1, ram_rdata_p1);

  always_comb begin
    hrdata = hrdata_hold;
    if (rd_vld_p1) hrdata = rd_merged_p1;
  end

endmodule
